intra_pred_nxn_seq: RTL and testbench

//  Parametrised, sequential NxN intra predictor: successor to the fixed 16x16 V/H/DC moder.

---
 rtl/intra_pred_nxn_seq.sv | 108 ++++++++++
 tb/tb_intra_pred_nxn_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/intra_pred_nxn_seq.sv
// intra_pred_nxn_seq: sequential NxN V/H/DC intra predictor with serial DC accumulation
// and one predicted row per cycle over a valid/ready stream.
module intra_pred_nxn_seq #(
    parameter int BLK     = 16,
    parameter int LOG2BLK = 4,
    parameter int PW      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                top_avail,
    input  logic                left_avail,
    input  logic [BLK*PW-1:0]   toppixels,
    input  logic [BLK*PW-1:0]   leftpixels,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLK*PW-1:0]   out_row,
    output logic [LOG2BLK-1:0]  out_row_idx,
    output logic                out_last,
    output logic                mode_err,
    output logic                done
);
    localparam int SW = PW + LOG2BLK;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t             state, state_nx;
    logic [BLK*PW-1:0]  top_r, left_r;
    logic [1:0]         mode_r;
    logic               ta_r, la_r;
    logic [SW-1:0]      sum_t, sum_l;
    logic [LOG2BLK-1:0] idx;
    logic               last_idx, fire, accept, use_v, use_h;
    logic [SW:0]        tot_both, tot_top, tot_left;
    logic [PW-1:0]      dc_val, left_pix;

    assign last_idx = idx == LOG2BLK'(BLK - 1);
    assign fire     = out_valid && out_ready;
    assign accept   = state == IDLE && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = accept                        ? ACCUM :
                   (state == ACCUM && last_idx)  ? EMIT  :
                   (state == EMIT && fire && last_idx) ? IDLE : state;
    end

    // idx counts accumulation steps in ACCUM and wraps to 0 to become the row index in EMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_r    <= '0;
            left_r   <= '0;
            mode_r   <= '0;
            ta_r     <= 1'b0;
            la_r     <= 1'b0;
            sum_t    <= '0;
            sum_l    <= '0;
            idx      <= '0;
            mode_err <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= state == EMIT && fire && last_idx;
            if (accept) begin
                top_r    <= toppixels;
                left_r   <= leftpixels;
                mode_r   <= mode;
                ta_r     <= top_avail;
                la_r     <= left_avail;
                sum_t    <= '0;
                sum_l    <= '0;
                idx      <= '0;
                mode_err <= (mode == 2'd0 && !top_avail) || (mode == 2'd1 && !left_avail);
            end else if (state == ACCUM) begin
                sum_t <= sum_t + SW'(top_r[idx*PW +: PW]);
                sum_l <= sum_l + SW'(left_r[idx*PW +: PW]);
                idx   <= idx + LOG2BLK'(1);
            end else if (fire) begin
                idx <= idx + LOG2BLK'(1);
            end
        end
    end

    always_comb begin
        use_v     = mode_r == 2'd0 && ta_r;
        use_h     = mode_r == 2'd1 && la_r;
        tot_both  = {1'b0, sum_t} + {1'b0, sum_l} + (SW+1)'(BLK);
        tot_top   = {1'b0, sum_t} + (SW+1)'(BLK / 2);
        tot_left  = {1'b0, sum_l} + (SW+1)'(BLK / 2);
        dc_val    = (ta_r && la_r) ? PW'(tot_both >> (LOG2BLK + 1)) :
                    ta_r           ? PW'(tot_top >> LOG2BLK) :
                    la_r           ? PW'(tot_left >> LOG2BLK) :
                                     {1'b1, {(PW-1){1'b0}}};
        left_pix  = left_r[idx*PW +: PW];
        busy      = state != IDLE;
        out_valid = state == EMIT;
        out_row   = !out_valid ? '0 : use_v ? top_r : use_h ? {BLK{left_pix}} : {BLK{dc_val}};
        out_row_idx = out_valid ? idx : '0;
        out_last  = out_valid && last_idx;
    end
endmodule

// File: tb/tb_intra_pred_nxn_seq.sv
// tb_intra_pred_nxn_seq: directed checks of V/H/DC prediction, latency, backpressure
// and reset abort for BLK=16, plus V/DC repeats for BLK=8 and BLK=4.
module tb_intra_pred_nxn_seq;
    logic clk = 1'b0, reset = 1'b1, ready = 1'b1, ta = 1'b1, la = 1'b1;
    logic [1:0] mode = '0;
    logic start16 = 0, start8 = 0, start4 = 0;
    logic [127:0] top16 = '0, left16 = '0, row16;
    logic [63:0]  top8 = '0, left8 = '0, row8;
    logic [31:0]  top4 = '0, left4 = '0, row4;
    logic [3:0] idx16;
    logic [2:0] idx8;
    logic [1:0] idx4;
    logic busy16, valid16, last16, err16, done16;
    logic busy8, valid8, last8, err8, done8;
    logic busy4, valid4, last4, err4, done4;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    intra_pred_nxn_seq #(.BLK(16), .LOG2BLK(4), .PW(8)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .mode(mode), .top_avail(ta), .left_avail(la),
        .toppixels(top16), .leftpixels(left16), .busy(busy16), .out_valid(valid16),
        .out_ready(ready), .out_row(row16), .out_row_idx(idx16), .out_last(last16),
        .mode_err(err16), .done(done16));
    intra_pred_nxn_seq #(.BLK(8), .LOG2BLK(3), .PW(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode), .top_avail(ta), .left_avail(la),
        .toppixels(top8), .leftpixels(left8), .busy(busy8), .out_valid(valid8),
        .out_ready(ready), .out_row(row8), .out_row_idx(idx8), .out_last(last8),
        .mode_err(err8), .done(done8));
    intra_pred_nxn_seq #(.BLK(4), .LOG2BLK(2), .PW(8)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode), .top_avail(ta), .left_avail(la),
        .toppixels(top4), .leftpixels(left4), .busy(busy4), .out_valid(valid4),
        .out_ready(ready), .out_row(row4), .out_row_idx(idx4), .out_last(last4),
        .mode_err(err4), .done(done4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a BLK=16 block, scramble the pixel inputs afterwards, and stop at the first EMIT cycle
    task automatic go16(input logic [1:0] m, input logic t, input logic l,
                        input logic [127:0] tp, input logic [127:0] lp);
        mode = m; ta = t; la = l; top16 = tp; left16 = lp; start16 = 1'b1;
        tick;
        start16 = 1'b0; top16 = ~tp; left16 = ~lp;
        repeat (16) tick;
    endtask

    task automatic rows16(input string tag, input logic [127:0] exp, input logic err);
        check({tag, "_err"}, err16, err);
        for (int r = 0; r < 16; r++) begin
            check(tag, row16, exp);
            check({tag, "_idx"}, idx16, r);
            tick;
        end
        check({tag, "_done"}, done16, 1'b1);
    endtask

    initial begin
        logic [127:0] e;
        int acc;
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy16, 0);
        check("rst_valid", valid16, 0);
        check("rst_row", row16, 0);
        check("rst_done", done16, 0);
        check("rst_err", err16, 0);
        reset = 1'b0;
        tick;
        // Test 1: vertical, top[i]=i
        for (int i = 0; i < 16; i++) top16[i*8 +: 8] = 8'(i);
        left16 = {16{8'h55}}; mode = 2'd0; ta = 1; la = 1; start16 = 1;
        e = top16;
        tick;
        start16 = 0; top16 = '1;
        check("t1_busy", busy16, 1);
        repeat (15) tick;
        check("t1_valid_c16", valid16, 0);
        tick;
        check("t1_valid_c17", valid16, 1);
        for (int r = 0; r < 16; r++) begin
            check("t1_row", row16, e);
            check("t1_idx", idx16, r);
            check("t1_last", last16, r == 15);
            tick;
        end
        check("t1_done_c33", done16, 1);
        check("t1_valid_off", valid16, 0);
        // Test 2: horizontal, started in the done cycle
        for (int j = 0; j < 16; j++) left16[j*8 +: 8] = 8'(16 * j);
        mode = 2'd1; start16 = 1;
        tick;
        start16 = 0; left16 = '0;
        check("t2_accepted", busy16, 1);
        check("t2_done_pulse", done16, 0);
        repeat (16) tick;
        for (int r = 0; r < 16; r++) begin
            check("t2_row", row16, {16{8'(16 * r)}});
            check("t2_last", last16, r == 15);
            tick;
        end
        check("t2_done", done16, 1);
        tick;
        check("t2_idle", busy16, 0);
        // Test 3 and 4: DC variants and fallbacks
        go16(2'd2, 1, 1, {16{8'd10}}, {16{8'd20}});
        rows16("t3_dc_both", {16{8'd15}}, 0);
        for (int i = 0; i < 16; i++) e[i*8 +: 8] = 8'(i + 1);
        go16(2'd2, 1, 0, e, {16{8'd200}});
        rows16("t4_dc_top", {16{8'd9}}, 0);
        go16(2'd2, 0, 0, e, {16{8'd200}});
        rows16("t4_dc_none", {16{8'd128}}, 0);
        go16(2'd0, 0, 1, e, {16{8'd20}});
        rows16("t4_v_fallback", {16{8'd20}}, 1);
        go16(2'd3, 1, 1, {16{8'd10}}, {16{8'd20}});
        rows16("t4_mode3", {16{8'd15}}, 0);
        go16(2'd1, 1, 0, e, {16{8'd20}});
        rows16("t4_h_fallback", {16{8'd9}}, 1);
        tick;
        // Test 5: backpressure at row 5, start pulsed during EMIT
        for (int i = 0; i < 16; i++) e[i*8 +: 8] = 8'(3 * i);
        go16(2'd0, 1, 1, e, '0);
        check("t5_err_cleared", err16, 0);
        acc = 0;
        for (int r = 0; r < 16; r++) begin
            if (r == 5) begin
                ready = 0; start16 = 1; mode = 2'd2;
                for (int k = 0; k < 3; k++) begin
                    tick;
                    check("t5_hold_row", row16, e);
                    check("t5_hold_idx", idx16, 5);
                end
                start16 = 0; ready = 1;
            end
            check("t5_row", row16, e);
            check("t5_idx", idx16, r);
            if (valid16 && ready) acc++;
            tick;
        end
        check("t5_done", done16, 1);
        check("t5_rows", acc, 16);
        tick;
        check("t5_idle", busy16, 0);
        // Test 6: reset mid-EMIT, then a clean block
        for (int i = 0; i < 16; i++) e[i*8 +: 8] = 8'(i);
        go16(2'd0, 1, 1, e, '0);
        repeat (7) tick;
        check("t6_at_row7", idx16, 7);
        #2 reset = 1;
        #1;
        check("t6_rst_valid", valid16, 0);
        check("t6_rst_row", row16, 0);
        check("t6_rst_busy", busy16, 0);
        tick;
        reset = 0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            seen |= done16;
        end
        check("t6_no_done", seen, 0);
        go16(2'd2, 1, 1, {16{8'd10}}, {16{8'd20}});
        rows16("t6_clean", {16{8'd15}}, 0);
        tick;
        // BLK=8 repeats
        for (int i = 0; i < 8; i++) top8[i*8 +: 8] = 8'(i);
        mode = 2'd0; ta = 1; la = 1; start8 = 1;
        e = 128'(top8);
        tick;
        start8 = 0; top8 = '1;
        repeat (7) tick;
        check("b8_valid_c8", valid8, 0);
        tick;
        check("b8_valid_c9", valid8, 1);
        for (int r = 0; r < 8; r++) begin
            check("b8_v_row", row8, e);
            check("b8_v_last", last8, r == 7);
            tick;
        end
        check("b8_v_done", done8, 1);
        top8 = {8{8'd10}}; left8 = {8{8'd20}}; mode = 2'd2; start8 = 1;
        tick;
        start8 = 0; top8 = '0;
        repeat (8) tick;
        for (int r = 0; r < 8; r++) begin
            check("b8_dc_row", row8, {8{8'd15}});
            tick;
        end
        check("b8_dc_done", done8, 1);
        // BLK=4 repeats
        for (int i = 0; i < 4; i++) top4[i*8 +: 8] = 8'(i);
        mode = 2'd0; start4 = 1;
        e = 128'(top4);
        tick;
        start4 = 0; top4 = '1;
        repeat (3) tick;
        check("b4_valid_c4", valid4, 0);
        tick;
        check("b4_valid_c5", valid4, 1);
        for (int r = 0; r < 4; r++) begin
            check("b4_v_row", row4, e);
            check("b4_v_idx", idx4, r);
            tick;
        end
        check("b4_v_done", done4, 1);
        top4 = {4{8'd10}}; left4 = {4{8'd20}}; mode = 2'd2; start4 = 1;
        tick;
        start4 = 0; left4 = '0;
        repeat (4) tick;
        for (int r = 0; r < 4; r++) begin
            check("b4_dc_row", row4, {4{8'd15}});
            tick;
        end
        check("b4_dc_done", done4, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
